// File: rtl/bram_pkg.sv
// Shared constants and encodings for the latency-controlled BRAM read path.
package bram_pkg;

    // Default read latency in cycles; legal range is 1..DELAYS_MAX.
    localparam int DELAYS_DEF = 10;
    localparam int DELAYS_MAX = 31;

    // Default geometry: 8K words of 32 bits.
    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    // Wide enough to count up to DELAYS_MAX outstanding reads.
    localparam int INFLIGHT_W = 5;

    // Read destination carried alongside each read through the pipeline.
    typedef enum logic {
        SEL_DMA = 1'b0,
        SEL_CPU = 1'b1
    } reader_sel_e;

endpackage

// File: rtl/bram_sp_array.sv
// Single-port synchronous RAM. A read returns the contents from before any
// write on the same edge (read-old-data). There is no reset, so the array
// maps onto block RAM and keeps its contents through a controller reset.
module bram_sp_array
    import bram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // One access per cycle: a write updates the array; a read registers the old word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_latency_ctrl.sv
// BRAM front end with fixed read latency. Reads enter a DELAYS-deep pipeline
// carrying valid, destination and data; the tail is demuxed onto the DMA or
// CPU return port as a one-cycle pulse. Each return data port holds its last
// delivered word between pulses.
module bram_latency_ctrl
    import bram_pkg::*;
#(
    parameter int DELAYS = DELAYS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  bram_in_valid,
    input  logic                  bram_wr,
    input  logic [ADDR_W-1:0]     bram_addr,
    input  logic [DATA_W-1:0]     bram_data_in,
    input  logic                  bram_reader_sel,
    output logic                  dma_rd_valid,
    output logic [DATA_W-1:0]     dma_rd_data,
    output logic                  cpu_rd_valid,
    output logic [DATA_W-1:0]     cpu_rd_data,
    output logic [INFLIGHT_W-1:0] rd_inflight
);

    // Requests seen while reset is high must not touch the array or the pipeline.
    logic req_ok;
    logic rd_acc;
    assign req_ok = bram_in_valid & ~wb_rst_i;
    assign rd_acc = req_ok & ~bram_wr;

    // The RAM output register is the first data stage of the latency pipeline.
    logic [DATA_W-1:0] mem_rdata;

    bram_sp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i   (wb_clk_i),
        .en_i    (req_ok),
        .we_i    (bram_wr),
        .addr_i  (bram_addr),
        .wdata_i (bram_data_in),
        .rdata_o (mem_rdata)
    );

    // Control pipeline: stage 0 loads on the accepting edge, alongside the RAM read.
    logic        [DELAYS-1:0] vld_pipe_q;
    reader_sel_e [DELAYS-1:0] sel_pipe_q;

    // Shift valid and destination one stage per cycle; reset drops in-flight reads.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vld_pipe_q <= '0;
            sel_pipe_q <= {DELAYS{SEL_DMA}};
        end else begin
            vld_pipe_q[0] <= rd_acc;
            sel_pipe_q[0] <= reader_sel_e'(bram_reader_sel);
            for (int s = 1; s < DELAYS; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                sel_pipe_q[s] <= sel_pipe_q[s-1];
            end
        end
    end

    // Data pipeline: with a single cycle of latency the RAM register is the tail;
    // otherwise extra unreset stages follow it. Data is qualified by vld_pipe_q.
    logic [DATA_W-1:0] tail_data;

    if (DELAYS == 1) begin : g_dp_none
        assign tail_data = mem_rdata;
    end else begin : g_dp
        logic [DELAYS-1:1][DATA_W-1:0] data_pipe_q;

        // Advance read data in lockstep with the valid bits.
        always_ff @(posedge wb_clk_i) begin
            data_pipe_q[1] <= mem_rdata;
            for (int s = 2; s < DELAYS; s++) begin
                data_pipe_q[s] <= data_pipe_q[s-1];
            end
        end

        assign tail_data = data_pipe_q[DELAYS-1];
    end

    logic        tail_vld;
    reader_sel_e tail_sel;
    assign tail_vld = vld_pipe_q[DELAYS-1];
    assign tail_sel = sel_pipe_q[DELAYS-1];

    // Exactly one destination can see the tail, so the valids are mutually exclusive.
    assign dma_rd_valid = tail_vld & (tail_sel == SEL_DMA);
    assign cpu_rd_valid = tail_vld & (tail_sel == SEL_CPU);

    // Last delivered word per destination, shown whenever that port is idle.
    logic [DATA_W-1:0] dma_hold_q;
    logic [DATA_W-1:0] cpu_hold_q;

    // Capture each delivered word so the port keeps presenting it afterwards.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dma_hold_q <= '0;
            cpu_hold_q <= '0;
        end else begin
            if (dma_rd_valid) dma_hold_q <= tail_data;
            if (cpu_rd_valid) cpu_hold_q <= tail_data;
        end
    end

    assign dma_rd_data = dma_rd_valid ? tail_data : dma_hold_q;
    assign cpu_rd_data = cpu_rd_valid ? tail_data : cpu_hold_q;

    // Outstanding-read counter: +1 on accept, -1 on delivery, unchanged on both.
    logic [INFLIGHT_W-1:0] inflight_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            inflight_q <= '0;
        end else begin
            case ({rd_acc, tail_vld})
                2'b10:   inflight_q <= inflight_q + INFLIGHT_W'(1);
                2'b01:   inflight_q <= inflight_q - INFLIGHT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign rd_inflight = inflight_q;

endmodule

// File: tb/tb_bram_latency_ctrl.sv
// Scoreboard bench for bram_latency_ctrl: one instance at the default latency
// and one at a latency of 1. Stimulus pushes hand-computed expected responses;
// per-instance monitors pop and compare on every response pulse.
module tb_bram_latency_ctrl;
    import bram_pkg::*;

    localparam int D0 = 10;
    localparam int D1 = 1;
    localparam int AW = 13;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0 (DELAYS=10)
    logic          v0 = 1'b0, w0 = 1'b0, s0 = 1'b0;
    logic [AW-1:0] a0 = '0;
    logic [DW-1:0] d0 = '0;
    logic          dv0, cv0;
    logic [DW-1:0] dd0, cd0;
    logic [4:0]    inf0;

    // Instance 1 (DELAYS=1)
    logic          v1 = 1'b0, w1 = 1'b0, s1 = 1'b0;
    logic [AW-1:0] a1 = '0;
    logic [DW-1:0] d1 = '0;
    logic          dv1, cv1;
    logic [DW-1:0] dd1, cd1;
    logic [4:0]    inf1;

    bram_latency_ctrl #(.DELAYS(D0), .ADDR_W(AW), .DATA_W(DW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .bram_in_valid(v0), .bram_wr(w0), .bram_addr(a0), .bram_data_in(d0),
        .bram_reader_sel(s0),
        .dma_rd_valid(dv0), .dma_rd_data(dd0),
        .cpu_rd_valid(cv0), .cpu_rd_data(cd0),
        .rd_inflight(inf0)
    );

    bram_latency_ctrl #(.DELAYS(D1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .bram_in_valid(v1), .bram_wr(w1), .bram_addr(a1), .bram_data_in(d1),
        .bram_reader_sel(s1),
        .dma_rd_valid(dv1), .dma_rd_data(dd1),
        .cpu_rd_valid(cv1), .cpu_rd_data(cd1),
        .rd_inflight(inf1)
    );

    typedef struct {
        int            issue;
        int            due;
        logic          sel;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for instance 0
    logic [DW-1:0] last_d0 = '0, last_c0 = '0;
    always @(negedge clk) begin : mon0
        int   n;
        exp_t e;
        if (rst) begin
            q0.delete();
            last_d0 = '0;
            last_c0 = '0;
            check("rst_valids0", 64'({dv0, cv0}), 64'(0));
            check("rst_inflight0", 64'(inf0), 64'(0));
            check("rst_data0", 64'({dd0, cd0}), 64'(0));
        end else begin
            n = 0;
            foreach (q0[i]) if (q0[i].issue < cyc && q0[i].due >= cyc) n++;
            check("inflight0", 64'(inf0), 64'(n));
            check("onehot0", 64'(dv0 & cv0), 64'(0));
            if (dv0 || cv0) begin
                if (q0.size() == 0) begin
                    check("spurious0", 64'({dv0, cv0}), 64'(0));
                end else begin
                    e = q0.pop_front();
                    check("latency0", 64'(cyc), 64'(e.due));
                    check("sel0", 64'(cv0), 64'(e.sel));
                    check("data0", 64'(cv0 ? cd0 : dd0), 64'(e.data));
                    if (cv0) last_c0 = e.data;
                    else     last_d0 = e.data;
                end
            end else if (q0.size() > 0 && q0[0].due <= cyc) begin
                check("missing0", 64'({dv0, cv0}), 64'(q0[0].sel ? 2'b01 : 2'b10));
                void'(q0.pop_front());
            end
            if (!dv0) check("hold_dma0", 64'(dd0), 64'(last_d0));
            if (!cv0) check("hold_cpu0", 64'(cd0), 64'(last_c0));
        end
    end

    // Monitor for instance 1
    logic [DW-1:0] last_d1 = '0, last_c1 = '0;
    always @(negedge clk) begin : mon1
        int   n;
        exp_t e;
        if (rst) begin
            q1.delete();
            last_d1 = '0;
            last_c1 = '0;
            check("rst_valids1", 64'({dv1, cv1}), 64'(0));
            check("rst_inflight1", 64'(inf1), 64'(0));
            check("rst_data1", 64'({dd1, cd1}), 64'(0));
        end else begin
            n = 0;
            foreach (q1[i]) if (q1[i].issue < cyc && q1[i].due >= cyc) n++;
            check("inflight1", 64'(inf1), 64'(n));
            check("onehot1", 64'(dv1 & cv1), 64'(0));
            if (dv1 || cv1) begin
                if (q1.size() == 0) begin
                    check("spurious1", 64'({dv1, cv1}), 64'(0));
                end else begin
                    e = q1.pop_front();
                    check("latency1", 64'(cyc), 64'(e.due));
                    check("sel1", 64'(cv1), 64'(e.sel));
                    check("data1", 64'(cv1 ? cd1 : dd1), 64'(e.data));
                    if (cv1) last_c1 = e.data;
                    else     last_d1 = e.data;
                end
            end else if (q1.size() > 0 && q1[0].due <= cyc) begin
                check("missing1", 64'({dv1, cv1}), 64'(q1[0].sel ? 2'b01 : 2'b10));
                void'(q1.pop_front());
            end
            if (!dv1) check("hold_dma1", 64'(dd1), 64'(last_d1));
            if (!cv1) check("hold_cpu1", 64'(cd1), 64'(last_c1));
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic op0(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic s);
        v0 = v; w0 = w; a0 = a; d0 = d; s0 = s;
        @(posedge clk); #1;
        v0 = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        op0(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd0(input logic [AW-1:0] a, input logic s, input logic [DW-1:0] x);
        exp_t e;
        e.issue = cyc; e.due = cyc + D0; e.sel = s; e.data = x;
        q0.push_back(e);
        op0(1'b1, 1'b0, a, '0, s);
    endtask

    task automatic op1(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic s);
        v1 = v; w1 = w; a1 = a; d1 = d; s1 = s;
        @(posedge clk); #1;
        v1 = 1'b0;
    endtask

    task automatic rd1(input logic [AW-1:0] a, input logic s, input logic [DW-1:0] x);
        exp_t e;
        e.issue = cyc; e.due = cyc + D1; e.sel = s; e.data = x;
        q1.push_back(e);
        op1(1'b1, 1'b0, a, '0, s);
    endtask

    initial begin : stim
        int pk;
        idle(3);
        rst = 1'b0;

        // Preload: addr 0..7 = addr, 0x010 = 1, 0x1FFF = 0xA5A51FFF; second instance 0..15 = 0x100+addr
        for (int i = 0; i < 8; i++) wr0(AW'(i), DW'(i));
        wr0(13'h010, 32'h1);
        wr0(13'h1FFF, 32'hA5A5_1FFF);
        for (int i = 0; i < 16; i++) op1(1'b1, 1'b1, AW'(i), DW'(32'h100 + i), 1'b0);

        // Eight back-to-back reads, alternating DMA/CPU; inflight must peak at 8
        pk = 0;
        for (int i = 0; i < 8; i++) rd0(AW'(i), i[0], DW'(i));
        repeat (14) begin
            if (int'(inf0) > pk) pk = int'(inf0);
            idle(1);
        end
        check("peak_inflight_8", 64'(pk), 64'(8));

        // Write then read next cycle to the CPU
        wr0(13'h005, 32'hDEAD_BEEF);
        rd0(13'h005, SEL_CPU, 32'hDEAD_BEEF);
        idle(12);

        // Read old value, overwrite next cycle, read new value
        rd0(13'h010, SEL_DMA, 32'h1);
        wr0(13'h010, 32'h2);
        rd0(13'h010, SEL_CPU, 32'h2);
        idle(12);

        // Requests without valid do nothing
        op0(1'b0, 1'b1, 13'h010, 32'h0BAD, 1'b1);
        op0(1'b0, 1'b0, 13'h010, 32'h0, 1'b0);
        rd0(13'h010, SEL_DMA, 32'h2);
        idle(12);

        // Top address and address 0 are distinct words
        rd0(13'h1FFF, SEL_DMA, 32'hA5A5_1FFF);
        rd0(13'h0000, SEL_CPU, 32'h0);
        idle(12);

        // Reset with five reads in flight; requests during reset are ignored
        for (int i = 0; i < 5; i++) rd0(AW'(i), i[0], DW'(i));
        idle(3);
        rst = 1'b1;
        op0(1'b1, 1'b1, 13'h003, 32'h0BAD, 1'b0);
        op0(1'b1, 1'b0, 13'h003, 32'h0, 1'b1);
        rst = 1'b0;
        idle(15);
        check("inflight_after_rst", 64'(inf0), 64'(0));
        rd0(13'h003, SEL_CPU, 32'h3);
        rd0(13'h005, SEL_DMA, 32'hDEAD_BEEF);
        idle(12);

        // Latency 1: 100 continuous reads, inflight never above 1
        pk = 0;
        for (int i = 0; i < 100; i++) begin
            if (int'(inf1) > pk) pk = int'(inf1);
            rd1(AW'(i % 16), i[1], DW'(32'h100 + (i % 16)));
        end
        repeat (3) begin
            if (int'(inf1) > pk) pk = int'(inf1);
            idle(1);
        end
        check("peak_inflight_d1", 64'(pk), 64'(1));
        check("queue_drained0", 64'(q0.size()), 64'(0));
        check("queue_drained1", 64'(q1.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bram_latency_ctrl.md
BRAM_LATENCY_CTRL -- requirements
Module: bram_latency_ctrl

Interface
REQ-001 The block SHALL have parameter DELAYS, default 10, meaning the read latency in cycles; legal range 1..31.
REQ-002 The block SHALL have parameter ADDR_W, default 13, meaning the word address width; memory depth is 2^ADDR_W words.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the word width.
REQ-004 The block SHALL have port wb_clk_i  input  1  clock; all logic is on its rising edge.
REQ-005 The block SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port bram_in_valid  input  1  request strobe, one request per cycle, no backpressure.
REQ-007 The block SHALL have port bram_wr  input  1  request type: 0 = read, 1 = write.
REQ-008 The block SHALL have port bram_addr  input  ADDR_W  word address.
REQ-009 The block SHALL have port bram_data_in  input  DATA_W  write data.
REQ-010 The block SHALL have port bram_reader_sel  input  1  read destination: 0 = DMA, 1 = CPU.
REQ-011 The block SHALL have port dma_rd_valid  output  1  DMA read data valid, one-cycle pulse.
REQ-012 The block SHALL have port dma_rd_data  output  DATA_W  DMA read data.
REQ-013 The block SHALL have port cpu_rd_valid  output  1  CPU read data valid, one-cycle pulse.
REQ-014 The block SHALL have port cpu_rd_data  output  DATA_W  CPU read data.
REQ-015 The block SHALL have port rd_inflight  output  5  count of reads accepted whose responses are still pending.

Function
REQ-016 Write: bram_in_valid=1 and bram_wr=1 at an edge SHALL store bram_data_in at bram_addr on that edge; bram_reader_sel is ignored.
REQ-017 Read: bram_in_valid=1 and bram_wr=0 at edge k SHALL capture mem[bram_addr] as of that edge, i.e. including all writes from earlier edges but not a same-edge write.
REQ-018 The captured read SHALL travel through a DELAYS-deep pipeline holding valid, reader_sel and data; exactly DELAYS cycles after acceptance, the selected valid SHALL be high for one cycle with its data.
REQ-019 Reads SHALL be fully pipelined: back-to-back reads on consecutive cycles SHALL produce consecutive response pulses, in issue order.
REQ-020 Only one of dma_rd_valid and cpu_rd_valid SHALL be high in any cycle.
REQ-021 rd_data of the non-selected destination, and of either destination while its valid is low, SHALL hold its last driven value.
REQ-022 rd_inflight SHALL increment on an accepted read, decrement on a response pulse, and stay unchanged when both occur on the same edge; its maximum is DELAYS.
REQ-023 Requests with bram_in_valid=0 SHALL have no effect, whatever the other inputs.
REQ-024 The address SHALL wrap naturally: all 2^ADDR_W addresses are valid, and no bounds error is raised.

Reset
REQ-025 While wb_rst_i=1, dma_rd_valid, cpu_rd_valid, rd_inflight, all pipeline valid bits, dma_rd_data and cpu_rd_data SHALL be 0.
REQ-026 Reset asserted while reads are in flight SHALL discard them, and no response pulse SHALL appear after reset release.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Requests presented while wb_rst_i=1 SHALL be ignored, and a write during reset SHALL NOT modify memory.

Structure
REQ-029 The default DELAYS value, the widths, and the reader_sel encodings (SEL_DMA=0, SEL_CPU=1) SHALL live in the shared package bram_pkg.
REQ-030 Storage SHALL be one sub-module, bram_sp_array: single port, synchronous read, write-first disabled (read-old-data).
REQ-031 The latency pipeline and the output demux SHALL be in bram_latency_ctrl itself.

Verification
REQ-032 Bench SHALL write 0xDEAD_BEEF to address 0x005 and, on the next cycle, read 0x005 with sel=CPU -> cpu_rd_valid exactly 10 cycles later with 0xDEAD_BEEF, and dma_rd_valid stays 0.
REQ-033 Bench SHALL issue 8 back-to-back reads of addresses 0..7 (preloaded with value=addr) with sel alternating DMA/CPU -> 8 consecutive pulses alternating destination with data 0..7, and rd_inflight peaks at 8.
REQ-034 Bench SHALL issue, on the same cycle, a read of 0x010 (old value 0x1) and then a write of 0x2 on the following cycle -> response 0x1; a second read -> 0x2.
REQ-035 Bench SHALL issue 5 reads, then assert reset 3 cycles later for 2 cycles -> no valid pulses afterward, rd_inflight=0, and previously written memory data still readable.
REQ-036 Bench SHALL write address 0x1FFF then read 0x1FFF and 0x0000 -> correct distinct data, with no aliasing.
REQ-037 Bench SHALL run continuous reads for 100 cycles with DELAYS=1 -> each response arrives the next cycle and rd_inflight never exceeds 1.
